pipe_ex_mem: RTL and testbench

The EX/MEM pipeline register of the pipelined processor. It captures the execute-stage results and the control signals still needed downstream on each rising clock edge, and presents them to the memory stage for one full cycle. It has no stall or flush inputs. Its only state-clearing mechanism is reset.

---
 rtl/pipe_ex_mem.sv | 58 +++++
 tb/tb_pipe_ex_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register: carries the execute-stage results and the
// control bits still needed by memory and write-back across one clock edge.
// There is no stall or flush. Every field loads on each rising edge while
// reset is low. Reset clears both write enables, so a cleared slot behaves
// as a NOP further down the pipe.
module pipe_ex_mem #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MEMWRITE_IN,
   input  logic             MEMTOREG_IN,
   input  logic             REGWRITE_IN,
   input  logic [WIDTH-1:0] RESULTOP_IN,
   input  logic [WIDTH-1:0] WRDATA_IN,
   input  logic [4:0]       ARD_IN,
   output logic             MEMWRITE_OUT,
   output logic             MEMTOREG_OUT,
   output logic             REGWRITE_OUT,
   output logic [WIDTH-1:0] RESULTOP_OUT,
   output logic [WIDTH-1:0] WRDATA_OUT,
   output logic [4:0]       ARD_OUT
);

   logic             memwrite_p1;
   logic             memtoreg_p1;
   logic             regwrite_p1;
   logic [WIDTH-1:0] resultop_p1;
   logic [WIDTH-1:0] wrdata_p1;
   logic [4:0]       ard_p1;

   // EX -> MEM boundary: capture every field each edge; reset clears all of them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memwrite_p1 <= 1'b0;
         memtoreg_p1 <= 1'b0;
         regwrite_p1 <= 1'b0;
         resultop_p1 <= '0;
         wrdata_p1   <= '0;
         ard_p1      <= 5'b00000;
      end else begin
         memwrite_p1 <= MEMWRITE_IN;
         memtoreg_p1 <= MEMTOREG_IN;
         regwrite_p1 <= REGWRITE_IN;
         resultop_p1 <= RESULTOP_IN;
         wrdata_p1   <= WRDATA_IN;
         ard_p1      <= ARD_IN;
      end
   end

   assign MEMWRITE_OUT = memwrite_p1;
   assign MEMTOREG_OUT = memtoreg_p1;
   assign REGWRITE_OUT = regwrite_p1;
   assign RESULTOP_OUT = resultop_p1;
   assign WRDATA_OUT   = wrdata_p1;
   assign ARD_OUT      = ard_p1;

endmodule

// File: tb/tb_pipe_ex_mem.sv
// Bench for the EX/MEM pipeline register: directed scenarios followed by a
// randomized run checked against a simple "outputs = inputs at last edge,
// or zero under reset" model.
`timescale 1ns/1ps
module tb_pipe_ex_mem;

   localparam int W  = 32;
   localparam int PW = 2*W + 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         mw_i, mt_i, rw_i;
   logic [W-1:0] res_i, wd_i;
   logic [4:0]   ard_i;
   logic         mw_o, mt_o, rw_o;
   logic [W-1:0] res_o, wd_o;
   logic [4:0]   ard_o;

   logic [PW-1:0] obs;
   logic [PW-1:0] exp_v;
   int            n_checks = 0;
   int            n_fail   = 0;

   always #5 clk = ~clk;

   pipe_ex_mem #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .MEMWRITE_IN  (mw_i),
      .MEMTOREG_IN  (mt_i),
      .REGWRITE_IN  (rw_i),
      .RESULTOP_IN  (res_i),
      .WRDATA_IN    (wd_i),
      .ARD_IN       (ard_i),
      .MEMWRITE_OUT (mw_o),
      .MEMTOREG_OUT (mt_o),
      .REGWRITE_OUT (rw_o),
      .RESULTOP_OUT (res_o),
      .WRDATA_OUT   (wd_o),
      .ARD_OUT      (ard_o)
   );

   assign obs = {mw_o, mt_o, rw_o, res_o, wd_o, ard_o};

   function automatic logic [PW-1:0] pack(input logic mw, input logic mt, input logic rw,
                                          input logic [W-1:0] r, input logic [W-1:0] d,
                                          input logic [4:0] a);
      return {mw, mt, rw, r, d, a};
   endfunction

   task automatic set_in(input logic mw, input logic mt, input logic rw,
                         input logic [W-1:0] r, input logic [W-1:0] d, input logic [4:0] a);
      mw_i = mw; mt_i = mt; rw_i = rw; res_i = r; wd_i = d; ard_i = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 5'b11111);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_edge%0d: got %h want %h", i, obs, {PW{1'b0}});
         end
         #3;
         n_checks++;
         if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid%0d: got %h want %h", i, obs, {PW{1'b0}});
         end
      end
   endtask

   task automatic test_capture();
      tick();
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h55555555, 5'b10101);
      tick();
      exp_v = pack(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h55555555, 5'b10101);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL capture: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [PW-1:0] prev;
      prev = pack(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h55555555, 5'b10101);
      set_in(1'b0, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 5'b01010);
      #3;
      n_checks++;
      if (obs !== prev) begin
         n_fail++;
         $display("FAIL b2b_hold: got %h want %h", obs, prev);
      end
      tick();
      exp_v = pack(1'b0, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 5'b01010);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL b2b_update: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_latency();
      logic [PW-1:0] held;
      held = pack(1'b0, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 5'b01010);
      set_in(1'b1, 1'b0, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 5'b10001);
      #2;
      n_checks++;
      if (obs !== held) begin
         n_fail++;
         $display("FAIL latency_mid1: got %h want %h", obs, held);
      end
      set_in(1'b1, 1'b1, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'b01110);
      #3;
      n_checks++;
      if (obs !== held) begin
         n_fail++;
         $display("FAIL latency_mid2: got %h want %h", obs, held);
      end
      // Put the reference values back before the edge so the outputs end on them.
      set_in(1'b0, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 5'b01010);
      tick();
      n_checks++;
      if (obs !== held) begin
         n_fail++;
         $display("FAIL latency_edge: got %h want %h", obs, held);
      end
   endtask

   task automatic test_async_reset();
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got %h want %h", obs, {PW{1'b0}});
      end
      tick();
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL async_reset_held: got %h want %h", obs, {PW{1'b0}});
      end
   endtask

   task automatic test_reset_release();
      #2;
      rst = 1'b0;
      set_in(1'b1, 1'b1, 1'b1, {W{1'b1}}, {W{1'b1}}, 5'b11111);
      #2;
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL release_before_edge: got %h want %h", obs, {PW{1'b0}});
      end
      tick();
      exp_v = pack(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b11111);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL release_first_edge: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_random();
      logic [PW-1:0] model;
      logic          r;
      model = pack(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b11111);
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 9) == 0);
         set_in(1'(($urandom)), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
         rst = r;
         #2;
         if (r) model = '0;
         n_checks++;
         if (obs !== model) begin
            n_fail++;
            $display("FAIL random_mid[%0d]: got %h want %h", i, obs, model);
         end
         tick();
         model = r ? '0 : {mw_i, mt_i, rw_i, res_i, wd_i, ard_i};
         n_checks++;
         if (obs !== model) begin
            n_fail++;
            $display("FAIL random_edge[%0d]: got %h want %h", i, obs, model);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
      test_reset();
      test_capture();
      test_back_to_back();
      test_latency();
      test_async_reset();
      test_reset_release();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
